// File: rtl/reg_write_arbiter_pkg.sv
// Shared processor constants for the register-file write arbiter.
// Holds datapath widths, requester IDs and small sizing helpers.
package reg_write_arbiter_pkg;

  localparam int unsigned ARCH_BITS    = 32;
  localparam int unsigned REG_IDX_BITS = 5;
  localparam int unsigned NUM_REQ      = 3;

  localparam int unsigned REQ_ALU = 0;
  localparam int unsigned REQ_MEM = 1;
  localparam int unsigned REQ_MUL = 2;

  // Index width able to address n requesters, never below one bit.
  function automatic int unsigned ptr_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_picker.sv
// Combinational round-robin picker: first eligible requester at or after ptr,
// wrapping from N-1 back to 0, returned as a one-hot grant.
module rr_picker
  import reg_write_arbiter_pkg::*;
#(
  parameter int unsigned N = 3
) (
  input  logic [N-1:0]           eligible,
  input  logic [ptr_bits(N)-1:0] ptr,
  output logic [N-1:0]           grant
);

  localparam int unsigned PTR_BITS = ptr_bits(N);

  logic                found;
  logic [PTR_BITS-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned off = 0; off < N; off++) begin
      idx = PTR_BITS'((32'(ptr) + off) % N);
      if (!found && eligible[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Arbitrates NUM_REQ writeback requesters onto register file port A with a
// one-entry output stage that stalls special writes while the rm bank is busy.
module reg_write_arbiter #(
  parameter int unsigned ARCH_BITS    = reg_write_arbiter_pkg::ARCH_BITS,
  parameter int unsigned REG_IDX_BITS = reg_write_arbiter_pkg::REG_IDX_BITS,
  parameter int unsigned NUM_REQ      = reg_write_arbiter_pkg::NUM_REQ
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              reqValid,
  output logic [NUM_REQ-1:0]              reqReady,
  input  logic [NUM_REQ*REG_IDX_BITS-1:0] reqDst,
  input  logic [NUM_REQ-1:0]              reqSpecial,
  input  logic [NUM_REQ*ARCH_BITS-1:0]    reqData,
  input  logic                            rmWriteEnable,
  output logic [REG_IDX_BITS-1:0]         dst,
  output logic                            specialDst,
  output logic [ARCH_BITS-1:0]            wData,
  output logic                            writeEnable,
  input  logic [REG_IDX_BITS-1:0]         qIdx,
  input  logic                            qSpecial,
  output logic                            qHit
);

  localparam int unsigned PTR_BITS = reg_write_arbiter_pkg::ptr_bits(NUM_REQ);

  logic                    out_valid_q, out_valid_d;
  logic [REG_IDX_BITS-1:0] dst_q, dst_d;
  logic                    special_q, special_d;
  logic [ARCH_BITS-1:0]    data_q, data_d;
  logic [PTR_BITS-1:0]     ptr_q, ptr_d;

  logic [NUM_REQ-1:0]      eligible;
  logic [NUM_REQ-1:0]      grant;
  logic                    hold;

  // Special writes collide with the exception unit's rm-bank port.
  assign eligible = reqValid & ~(reqSpecial & {NUM_REQ{rmWriteEnable}});
  assign hold     = out_valid_q & rmWriteEnable & special_q;

  rr_picker #(.N(NUM_REQ)) u_picker (
    .eligible (eligible),
    .ptr      (ptr_q),
    .grant    (grant)
  );

  assign reqReady    = (rst || hold) ? '0 : grant;
  assign writeEnable = out_valid_q & ~rst & ~(rmWriteEnable & special_q);
  assign dst         = dst_q;
  assign specialDst  = special_q;
  assign wData       = data_q;

  // Output stage and round-robin pointer state.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      dst_q       <= '0;
      special_q   <= 1'b0;
      data_q      <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      dst_q       <= dst_d;
      special_q   <= special_d;
      data_q      <= data_d;
      ptr_q       <= ptr_d;
    end
  end

  // Next state: a held entry stays put; otherwise load the granted request.
  always_comb begin
    out_valid_d = hold | (|reqReady);
    dst_d       = dst_q;
    special_d   = special_q;
    data_d      = data_q;
    ptr_d       = ptr_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (reqReady[i]) begin
        dst_d     = reqDst[i*REG_IDX_BITS +: REG_IDX_BITS];
        special_d = reqSpecial[i];
        data_d    = reqData[i*ARCH_BITS +: ARCH_BITS];
        ptr_d     = (i == NUM_REQ - 1) ? '0 : PTR_BITS'(i + 1);
      end
    end
  end

  // Hazard query against the output stage and every pending request.
  always_comb begin
    qHit = 1'b0;
    if (!rst && out_valid_q && special_q == qSpecial && dst_q == qIdx) begin
      qHit = 1'b1;
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (reqValid[i] && reqSpecial[i] == qSpecial &&
          reqDst[i*REG_IDX_BITS +: REG_IDX_BITS] == qIdx) begin
        qHit = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed scenarios followed by randomized traffic, every cycle compared
// against a queue-free behavioural model of the arbiter's rules.
module tb_reg_write_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int RW = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    reqValid, reqReady, reqSpecial;
  logic [N*RW-1:0] reqDst;
  logic [N*AW-1:0] reqData;
  logic            rmWriteEnable;
  logic [RW-1:0]   dst;
  logic            specialDst;
  logic [AW-1:0]   wData;
  logic            writeEnable;
  logic [RW-1:0]   qIdx;
  logic            qSpecial;
  logic            qHit;

  int checks = 0;
  int errors = 0;

  // Requester-side stimulus
  logic          v [N];
  logic [RW-1:0] d [N];
  logic          s [N];
  logic [AW-1:0] x [N];

  // Reference model state
  bit            m_valid;
  logic [RW-1:0] m_dst;
  bit            m_spec;
  logic [AW-1:0] m_data;
  int            m_ptr;
  int            m_grant;

  // DUT values sampled mid-cycle by the last call of cycle()
  logic [N-1:0]  o_ready;
  logic          o_we, o_hit, o_spec;
  logic [RW-1:0] o_dst;
  logic [AW-1:0] o_data;

  always #5 clk = ~clk;

  reg_write_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .reqValid      (reqValid),
    .reqReady      (reqReady),
    .reqDst        (reqDst),
    .reqSpecial    (reqSpecial),
    .reqData       (reqData),
    .rmWriteEnable (rmWriteEnable),
    .dst           (dst),
    .specialDst    (specialDst),
    .wData         (wData),
    .writeEnable   (writeEnable),
    .qIdx          (qIdx),
    .qSpecial      (qSpecial),
    .qHit          (qHit)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply stimulus, compare mid-cycle, then advance the model across the edge.
  task automatic cycle();
    logic [N-1:0] exp_ready;
    bit           hold, exp_we, exp_hit;
    int           g;
    for (int i = 0; i < N; i++) begin
      reqValid[i]          = v[i];
      reqSpecial[i]        = s[i];
      reqDst[i*RW +: RW]   = d[i];
      reqData[i*AW +: AW]  = x[i];
    end
    #2;
    hold   = m_valid && rmWriteEnable && m_spec && !rst;
    exp_we = m_valid && !rst && !(rmWriteEnable && m_spec);
    g = -1;
    if (!rst && !hold) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (g < 0 && v[c] && !(s[c] && rmWriteEnable)) g = c;
      end
    end
    exp_ready = (g >= 0) ? N'(1 << g) : '0;
    exp_hit   = !rst && m_valid && (m_spec == qSpecial) && (m_dst == qIdx);
    for (int i = 0; i < N; i++) begin
      if (v[i] && s[i] == qSpecial && d[i] == qIdx) exp_hit = 1'b1;
    end
    o_ready = reqReady; o_we = writeEnable; o_hit = qHit;
    o_dst = dst; o_spec = specialDst; o_data = wData;
    check("reqReady", 32'(o_ready), 32'(exp_ready));
    check("writeEnable", 32'(o_we), 32'(exp_we));
    check("qHit", 32'(o_hit), 32'(exp_hit));
    if (!rst) begin
      check("dst", 32'(o_dst), 32'(m_dst));
      check("specialDst", 32'(o_spec), 32'(m_spec));
      check("wData", o_data, m_data);
    end
    @(posedge clk);
    m_grant = g;
    if (rst) begin
      m_valid = 1'b0; m_dst = '0; m_spec = 1'b0; m_data = '0; m_ptr = 0;
    end else if (!hold) begin
      m_valid = (g >= 0);
      if (g >= 0) begin
        m_dst = d[g]; m_spec = s[g]; m_data = x[g];
        m_ptr = (g + 1) % N;
      end
    end
    #1;
  endtask

  task automatic idle_reqs();
    for (int i = 0; i < N; i++) begin
      v[i] = 1'b0; d[i] = '0; s[i] = 1'b0; x[i] = '0;
    end
  endtask

  initial begin
    m_valid = 1'b0; m_dst = '0; m_spec = 1'b0; m_data = '0; m_ptr = 0; m_grant = -1;
    idle_reqs();
    rst = 1'b1; rmWriteEnable = 1'b0; qIdx = '0; qSpecial = 1'b0;
    reqValid = '0; reqSpecial = '0; reqDst = '0; reqData = '0;
    @(posedge clk); #1;

    // Reset state
    cycle();
    cycle();
    rst = 1'b0;
    qIdx = 5'd31; qSpecial = 1'b1;

    // All three requesters continuously valid, dst 7 general
    for (int i = 0; i < N; i++) begin
      v[i] = 1'b1; d[i] = 5'd7; x[i] = 32'h100 + 32'(i);
    end
    cycle();
    check("reset_we", 32'(o_we), 32'd0);
    check("reset_dst", 32'(o_dst), 32'd0);
    check("reset_wdata", o_data, 32'd0);
    check("rr_grant0", 32'(o_ready), 32'b001);
    cycle();
    check("rr_grant1", 32'(o_ready), 32'b010);
    check("rr_we1", 32'(o_we), 32'd1);
    cycle();
    check("rr_grant2", 32'(o_ready), 32'b100);
    check("rr_we2", 32'(o_we), 32'd1);
    cycle();
    check("rr_grant3", 32'(o_ready), 32'b001);
    check("rr_we3", 32'(o_we), 32'd1);
    idle_reqs();
    cycle();
    cycle();
    check("idle_we", 32'(o_we), 32'd0);

    // Single MEM request
    v[1] = 1'b1; d[1] = 5'd3; x[1] = 32'hDEADBEEF;
    cycle();
    check("mem_ready", 32'(o_ready), 32'b010);
    v[1] = 1'b0;
    cycle();
    check("mem_we", 32'(o_we), 32'd1);
    check("mem_dst", 32'(o_dst), 32'd3);
    check("mem_wdata", o_data, 32'hDEADBEEF);
    cycle();
    check("mem_we_drop", 32'(o_we), 32'd0);
    check("mem_dst_held", 32'(o_dst), 32'd3);

    // Special request skipped while the rm bank is busy
    rmWriteEnable = 1'b1;
    v[0] = 1'b1; s[0] = 1'b1; d[0] = 5'd2; x[0] = 32'hA0;
    v[2] = 1'b1; s[2] = 1'b0; d[2] = 5'd9; x[2] = 32'hA2;
    cycle();
    check("skip_special", 32'(o_ready), 32'b100);
    v[2] = 1'b0; rmWriteEnable = 1'b0;
    cycle();
    check("special_after", 32'(o_ready), 32'b001);
    v[0] = 1'b0;
    cycle();
    check("special_written", 32'(o_spec), 32'd1);

    // Output stage held while rm bank busy
    v[0] = 1'b1; s[0] = 1'b1; d[0] = 5'd4; x[0] = 32'hB4;
    cycle();
    v[0] = 1'b0;
    v[1] = 1'b1; s[1] = 1'b0; d[1] = 5'd11; x[1] = 32'hB11;
    rmWriteEnable = 1'b1;
    cycle();
    check("hold_we", 32'(o_we), 32'd0);
    check("hold_ready", 32'(o_ready), 32'b000);
    rmWriteEnable = 1'b0;
    cycle();
    check("hold_release_we", 32'(o_we), 32'd1);
    check("hold_release_dst", 32'(o_dst), 32'd4);
    v[1] = 1'b0;
    cycle();

    // Hazard query: special and general index 5 never alias
    qIdx = 5'd5; qSpecial = 1'b0; rmWriteEnable = 1'b1;
    v[2] = 1'b1; s[2] = 1'b1; d[2] = 5'd5; x[2] = 32'hC5;
    cycle();
    check("qhit_alias", 32'(o_hit), 32'd0);
    s[2] = 1'b0;
    cycle();
    check("qhit_match", 32'(o_hit), 32'd1);
    v[2] = 1'b0; rmWriteEnable = 1'b0;
    cycle();
    check("qhit_stage", 32'(o_hit), 32'd1);

    // Reset right after an accept discards the entry and the pointer
    v[1] = 1'b1; d[1] = 5'd6; x[1] = 32'hD6;
    cycle();
    v[1] = 1'b0; rst = 1'b1;
    cycle();
    check("rst_we", 32'(o_we), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      v[i] = 1'b1; d[i] = 5'd1; x[i] = 32'hE0 + 32'(i);
    end
    cycle();
    check("rst_we_after", 32'(o_we), 32'd0);
    check("rst_ptr", 32'(o_ready), 32'b001);
    idle_reqs();
    cycle();

    // Randomized traffic; requests stay stable until accepted
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!v[i] && ($urandom % 3 == 0)) begin
          v[i] = 1'b1;
          d[i] = RW'($urandom % 8);
          s[i] = ($urandom % 4 == 0);
          x[i] = $urandom;
        end
      end
      rmWriteEnable = ($urandom % 3 == 0);
      qIdx          = RW'($urandom % 8);
      qSpecial      = ($urandom % 4 == 0);
      rst           = ($urandom % 60 == 0);
      cycle();
      if (m_grant >= 0) v[m_grant] = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 SHALL have parameter ARCH_BITS, default 32, data word width.
REQ-002 SHALL have parameter REG_IDX_BITS, default 5, register index width.
REQ-003 SHALL have parameter NUM_REQ, default 3, requester count (0=ALU, 1=MEM, 2=MUL).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port reqValid  input  NUM_REQ  per-requester write request.
REQ-007 SHALL have port reqReady  output  NUM_REQ  per-requester accept, one-hot or zero.
REQ-008 SHALL have port reqDst  input  NUM_REQ*REG_IDX_BITS  packed destination indices, requester i at slice i.
REQ-009 SHALL have port reqSpecial  input  NUM_REQ  destination is a special register (rm bank).
REQ-010 SHALL have port reqData  input  NUM_REQ*ARCH_BITS  packed write data.
REQ-011 SHALL have port rmWriteEnable  input  1  exception unit writing rm0/rm1/rm2/rm4 this cycle.
REQ-012 SHALL have port dst  output  REG_IDX_BITS  register file port A destination.
REQ-013 SHALL have port specialDst  output  1  register file port A special select.
REQ-014 SHALL have port wData  output  ARCH_BITS  register file port A data.
REQ-015 SHALL have port writeEnable  output  1  register file port A write strobe.
REQ-016 SHALL have port qIdx  input  REG_IDX_BITS  hazard query index.
REQ-017 SHALL have port qSpecial  input  1  hazard query special select.
REQ-018 SHALL have port qHit  output  1  query register has a write pending (combinational).

Function
REQ-019 SHALL accept requester i (reqValid[i] && reqReady[i]) in at most one requester per cycle.
REQ-020 SHALL grant by round-robin: search starts at rrPtr, wraps NUM_REQ-1 -> 0; after a grant to i, rrPtr = (i+1) mod NUM_REQ; no grant -> rrPtr unchanged.
REQ-021 SHALL treat a request with reqSpecial=1 as ineligible in any cycle with rmWriteEnable=1; the search skips it and grants the next eligible requester.
REQ-022 SHALL register the accepted request into the output stage at the posedge ending the accept cycle; writeEnable=1 with matching dst/specialDst/wData for exactly the following cycle (latency 1).
REQ-023 SHALL drive writeEnable=0 in any cycle whose preceding cycle had no accept; dst/specialDst/wData then hold last values.
REQ-024 SHALL sustain one write per cycle under continuous requests (no bubbles).
REQ-025 SHALL drop writeEnable to 0 in the output-stage cycle if rmWriteEnable=1 and specialDst=1 would be driven, holding the entry and re-presenting it next cycle; reqReady is all zero while an entry is held.
REQ-026 SHALL assert reqReady combinationally from current reqValid, rrPtr, rmWriteEnable and hold state only; no dependence on payload except reqSpecial.
REQ-027 SHALL require requesters to keep reqValid and payload stable until accepted; behaviour on retraction is undefined.
REQ-028 SHALL assert qHit when {qSpecial,qIdx} equals {specialDst,dst} of a valid or held output-stage entry, or {reqSpecial[i],reqDst[i]} of any reqValid[i].
REQ-029 SHALL compare special/general indices distinctly: {0,5} and {1,5} never alias.

Reset
REQ-030 SHALL on rst=1 at posedge set writeEnable=0, hold state=0, rrPtr=0, dst=0, specialDst=0, wData=0.
REQ-031 SHALL drive reqReady=0 and qHit from inputs only while rst=1; an in-flight output entry is discarded, not written.

Structure
REQ-032 SHALL take ARCH_BITS and REG_IDX_BITS from the shared processor constants package; requester IDs (REQ_ALU=0, REQ_MEM=1, REQ_MUL=2) SHALL live there too.
REQ-033 SHALL use one sub-module rr_picker (NUM_REQ-wide eligible vector + pointer in, one-hot grant out, combinational).

Verification
REQ-034 SHALL cover: reset then reqValid=3'b111 held, all dst=7 general -> grants 0,1,2,0 on consecutive cycles, writeEnable high each cycle after first.
REQ-035 SHALL cover: only req1 valid, dst=3, data=0xDEADBEEF -> reqReady=3'b010 same cycle, next cycle writeEnable=1, dst=3, wData=0xDEADBEEF, then writeEnable=0.
REQ-036 SHALL cover: rmWriteEnable=1, req0 special dst=2, req2 general dst=9 -> req2 granted, req0 granted first cycle rmWriteEnable=0.
REQ-037 SHALL cover: output stage holds special dst=4 while rmWriteEnable=1 -> writeEnable=0, reqReady=0, write issued next cycle with rmWriteEnable=0.
REQ-038 SHALL cover: qIdx=5, qSpecial=0 with req2 pending dst=5 special=1 -> qHit=0; with special=0 -> qHit=1.
REQ-039 SHALL cover: rst asserted in cycle after accept -> writeEnable=0 next cycle, rrPtr=0.
